// File: rtl/act_serializer_if.sv
// Bus between the bias-add stage (frame source, downstream sink) and act_serializer.
// Handshake: an element transfers on a rising edge where m_valid & m_ready; m_data/m_ch/m_row/m_last hold while m_valid & !m_ready.
interface act_serializer_if #(
  parameter int DATA_LEN = 18,
  parameter int ROWS     = 12,
  parameter int CH       = 32
);
  localparam int CH_W  = $clog2(CH);
  localparam int ROW_W = $clog2(ROWS);

  logic                         load;
  logic [ROWS*CH*DATA_LEN-1:0]  d;
  logic                         busy;
  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_LEN-1:0]          m_data;
  logic [CH_W-1:0]              m_ch;
  logic [ROW_W-1:0]             m_row;
  logic                         m_last;
  logic                         done;
  logic                         drop;

  modport master (
    input  load, d, m_ready,
    output busy, m_valid, m_data, m_ch, m_row, m_last, done, drop
  );

  modport slave (
    output load, d, m_ready,
    input  busy, m_valid, m_data, m_ch, m_row, m_last, done, drop
  );
endinterface

// File: rtl/act_serializer.sv
// Captures a ROWS x CH activation frame on load and streams it one element per
// handshake, channel-major, with channel/row tags, last flag and done/drop pulses.
module act_serializer #(
  parameter int DATA_LEN = 18,
  parameter int ROWS     = 12,
  parameter int CH       = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  act_serializer_if.master bus
);
  localparam int N     = ROWS * CH;
  localparam int K_W   = $clog2(N);
  localparam int CH_W  = $clog2(CH);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(N - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  // busy is the registered state bit, so it doubles as the FSM debug view.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_LEN-1:0] frame_q [N];
  logic [DATA_LEN-1:0] frame_d [N];
  logic [K_W-1:0]      k_q, k_d, k_nxt;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_LEN-1:0] m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                hs, final_hs, start;

  always_comb begin
    k_nxt     = k_q + K_W'(1);
    hs        = m_valid_q & bus.m_ready;
    final_hs  = hs & (k_q == K_LAST);
    // A load landing on the final handshake chains the next frame with no gap.
    start     = bus.load & ((state_q == IDLE) | final_hs);

    state_d   = state_q;
    frame_d   = frame_q;
    k_d       = k_q;
    ch_d      = ch_q;
    row_d     = row_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = final_hs;
    drop_d    = bus.load & (state_q == SEND) & ~final_hs;

    if (start) begin
      for (int i = 0; i < N; i++) frame_d[i] = bus.d[i*DATA_LEN +: DATA_LEN];
      state_d   = SEND;
      k_d       = '0;
      ch_d      = '0;
      row_d     = '0;
      m_valid_d = 1'b1;
      m_last_d  = (K_LAST == '0);
      m_data_d  = bus.d[DATA_LEN-1:0];
    end else if (final_hs) begin
      state_d   = IDLE;
      k_d       = '0;
      ch_d      = '0;
      row_d     = '0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_data_d  = '0;
    end else if (hs) begin
      k_d      = k_nxt;
      m_data_d = frame_q[k_nxt];
      m_last_d = (k_nxt == K_LAST);
      if (row_q == ROW_LAST) begin
        row_d = '0;
        ch_d  = ch_q + CH_W'(1);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      for (int i = 0; i < N; i++) frame_q[i] <= '0;
      k_q       <= '0;
      ch_q      <= '0;
      row_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      k_q       <= k_d;
      ch_q      <= ch_d;
      row_q     <= row_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.busy    = (state_q == SEND);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_ch    = ch_q;
  assign bus.m_row   = row_q;
  assign bus.m_last  = m_last_q;
  assign bus.done    = done_q;
  assign bus.drop    = drop_q;
endmodule
